// File: rtl/calc_io_pkg.sv
// Shared types and constants for the calculator I/O paths: the keypad scanner
// FSM states, the keypad index map and the shift-register timing constants.
package calc_io_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, EVAL} scan_state_e;

  localparam int KEY_0 = 0,  KEY_1 = 1,  KEY_2 = 2,  KEY_3 = 3;
  localparam int KEY_4 = 4,  KEY_5 = 5,  KEY_6 = 6,  KEY_7 = 7;
  localparam int KEY_8 = 8,  KEY_9 = 9,  KEY_A = 10, KEY_B = 11;
  localparam int KEY_C = 12, KEY_D = 13, KEY_E = 14, KEY_F = 15;
  localparam int KEY_ADD = 16, KEY_SUB = 17, KEY_EQ = 18, KEY_CLR = 19;

  // Both 74HC595 and 74HC165 chains run one bit per two system clocks.
  localparam int SR_BITS_PER_DEVICE  = 8;
  localparam int SR_CYCLES_PER_BIT   = 2;
  localparam int SR_DEFAULT_PERIOD   = 1024;

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event handshake between the keypad scanner (master) and the calculator core.
interface keypad_scanner_if #(
  parameter int KEY_W = 4
);
  logic [KEY_W-1:0] o_key;
  logic             o_valid;
  logic             i_ready;

  modport master (output o_key, output o_valid, input i_ready);
  modport slave  (input o_key, input o_valid, output i_ready);
endinterface

// File: rtl/key_debouncer.sv
// Per-key debouncer: the level flips only after DEBOUNCE_SCANS consecutive
// disagreeing samples; rise_o pulses in the evaluation cycle of a release-to-press flip.
module key_debouncer #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic eval_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (eval_i) begin
      if (raw_i == level_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = ~level_q & level_d;
endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner: loads and shifts a 74HC165 chain, debounces every key, queues
// press events and hands them out lowest index first. Auto-repeat: KEYPAD_SCANNER_AUTOREPEAT_EN.
module keypad_scanner
  import calc_io_pkg::*;
#(
  parameter int NUM_KEYS       = 16,
  parameter int SCAN_PERIOD    = 1024,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sr_data,
  output logic o_sr_clk,
  output logic o_sr_load_n,
  keypad_scanner_if.master kbus
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam int TW = $clog2(SCAN_PERIOD);

  scan_state_e         state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [KW-1:0]       bit_q, bit_d;
  logic                phase_q, phase_d;
  logic [NUM_KEYS-1:0] raw_q;
  logic                eval;
  logic                sr_clk_q, sr_load_n_q;
  logic [NUM_KEYS-1:0] deb, rise, set_vec, clr_vec;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [KW-1:0]       key_q, key_d;
  logic                valid_q, valid_d;

  function automatic logic [KW-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = KW'(i);
  endfunction

  assign timer_d = (timer_q == TW'(SCAN_PERIOD - 1)) ? '0 : timer_q + 1'b1;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: if (timer_q == TW'(SCAN_PERIOD - 1)) state_d = LOAD;
      LOAD: begin
        state_d = SHIFT;
        bit_d   = KW'(NUM_KEYS - 1);
        phase_d = 1'b0;
      end
      SHIFT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (bit_q == '0) state_d = EVAL;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      EVAL: begin
        eval    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      raw_q       <= '0;
      sr_clk_q    <= 1'b0;
      sr_load_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      sr_clk_q    <= (state_d == SHIFT) && phase_d;
      sr_load_n_q <= (state_d != LOAD);
      if (state_q == SHIFT && !phase_q) raw_q[bit_q] <= ~i_sr_data;
    end
  end

  assign o_sr_clk    = sr_clk_q;
  assign o_sr_load_n = sr_load_n_q;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_deb
    key_debouncer #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_q[gi]),
      .eval_i (eval),
      .level_o(deb[gi]),
      .rise_o (rise[gi])
    );
  end

`ifdef KEYPAD_SCANNER_AUTOREPEAT_EN
  localparam int REP_INT = (REPEAT_SCANS / 4 < 1) ? 1 : REPEAT_SCANS / 4;
  localparam int HW      = $clog2(REPEAT_SCANS + 1);

  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [KW-1:0]       hold_key_q, hold_key_d;
  logic                hold_vld_q, hold_vld_d;
  logic [NUM_KEYS-1:0] rep_set;

  // Hold tracking sees the pre-update debounced levels, so the first held EVAL counts as 1.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_key_d = hold_key_q;
    hold_vld_d = hold_vld_q;
    rep_set    = '0;
    if (eval) begin
      if (deb == '0) begin
        hold_vld_d = 1'b0;
        hold_cnt_d = '0;
      end else if (!hold_vld_q || hold_key_q != lowest_idx(deb)) begin
        hold_vld_d = 1'b1;
        hold_key_d = lowest_idx(deb);
        hold_cnt_d = HW'(1);
      end else if (int'(hold_cnt_q) + 1 >= REPEAT_SCANS) begin
        rep_set[hold_key_q] = 1'b1;
        hold_cnt_d          = HW'(REPEAT_SCANS - REP_INT);
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      hold_key_q <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_key_q <= hold_key_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign set_vec = rise | rep_set;
`else
  logic deb_unused;
  assign deb_unused = ^deb;
  assign set_vec    = rise;
`endif

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    clr_vec = '0;
    if (valid_q) begin
      if (kbus.i_ready) valid_d = 1'b0;
    end else if (pending_q != '0) begin
      valid_d          = 1'b1;
      key_d            = lowest_idx(pending_q);
      clr_vec[key_d]   = 1'b1;
    end
  end

  // Set is applied after clear so a re-press of the bit being handed out is kept.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      key_q     <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      key_q     <= key_d;
    end
  end

  assign kbus.o_key   = key_q;
  assign kbus.o_valid = valid_q;
endmodule
